// File: rtl/lfsr_prbs_checker_if.sv
// lfsr_prbs_checker_if: received PRBS word stream plus checker status and error counters
interface lfsr_prbs_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0]            data_in;
    logic                             data_valid;
    logic                             clear;
    logic                             locked;
    logic                             err_word;
    logic [$clog2(DATA_WIDTH+1)-1:0]  err_bits;
    logic [CNT_WIDTH-1:0]             bit_err_count;
    logic [CNT_WIDTH-1:0]             word_err_count;
    modport master (
        output data_in, data_valid, clear,
        input  locked, err_word, err_bits, bit_err_count, word_err_count
    );
    modport slave (
        input  data_in, data_valid, clear,
        output locked, err_word, err_bits, bit_err_count, word_err_count
    );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising PRBS checker with lock tracking and saturating error counters
module lfsr_prbs_checker #(
    parameter int                    LFSR_WIDTH = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 9'h021,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LOCK_COUNT = 4,
    parameter int                    LOSS_COUNT = 4,
    parameter int                    ERR_THRESH = 2,
    parameter int                    CNT_WIDTH  = 32
) (
    input logic clk,
    input logic rst,
    lfsr_prbs_checker_if.slave bus
);
    localparam int EW = $clog2(DATA_WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t                state, state_n;
    logic [LFSR_WIDTH-1:0] lfsr, lfsr_n, pred, load;
    logic [DATA_WIDTH-1:0] expect_w;
    logic [EW-1:0]         nerr, err_bits_q, err_bits_n, add_b;
    logic [MW-1:0]         match, match_n;
    logic [BW-1:0]         bad, bad_n;
    logic                  err_word_q, err_word_n, counted;
    logic [CNT_WIDTH-1:0]  bit_cnt, word_cnt, bit_cnt_n, word_cnt_n, base_b, base_w;
    logic [CNT_WIDTH:0]    bsum, wsum;
    // State bit LFSR_WIDTH-1 holds the newest bit, bit 0 the oldest; words run MSB first in time.
    always_comb begin
        pred     = lfsr;
        load     = lfsr;
        expect_w = '0;
        nerr     = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            expect_w[k] = ^(pred & LFSR_POLY);
            pred        = {expect_w[k], pred[LFSR_WIDTH-1:1]};
            load        = {bus.data_in[k], load[LFSR_WIDTH-1:1]};
            nerr        = nerr + EW'(expect_w[k] ^ bus.data_in[k]);
        end
    end
    always_comb begin
        state_n    = state;
        lfsr_n     = lfsr;
        match_n    = match;
        bad_n      = bad;
        counted    = bus.data_valid && state == LOCKED;
        err_word_n = counted && nerr != '0;
        err_bits_n = bus.data_valid ? nerr : '0;
        if (bus.data_valid && state == HUNT) begin
            lfsr_n  = load;
            match_n = (nerr == '0 && lfsr != '0) ? match + 1'b1 : '0;
            if (int'(match_n) == LOCK_COUNT) begin
                state_n = LOCKED;
                match_n = '0;
                bad_n   = '0;
            end
        end else if (counted) begin
            lfsr_n = pred;
            bad_n  = (int'(nerr) >= ERR_THRESH) ? bad + 1'b1 : '0;
            if (int'(bad_n) == LOSS_COUNT) begin
                state_n = HUNT;
                bad_n   = '0;
                match_n = '0;
            end
        end
        base_b     = bus.clear ? '0 : bit_cnt;
        base_w     = bus.clear ? '0 : word_cnt;
        add_b      = counted ? nerr : '0;
        bsum       = {1'b0, base_b} + (CNT_WIDTH+1)'(add_b);
        wsum       = {1'b0, base_w} + (CNT_WIDTH+1)'(err_word_n);
        bit_cnt_n  = bsum[CNT_WIDTH] ? '1 : bsum[CNT_WIDTH-1:0];
        word_cnt_n = wsum[CNT_WIDTH] ? '1 : wsum[CNT_WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            lfsr       <= '0;
            match      <= '0;
            bad        <= '0;
            err_word_q <= 1'b0;
            err_bits_q <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            match      <= match_n;
            bad        <= bad_n;
            err_word_q <= err_word_n;
            err_bits_q <= err_bits_n;
            bit_cnt    <= bit_cnt_n;
            word_cnt   <= word_cnt_n;
        end
    end
    assign bus.locked         = state == LOCKED;
    assign bus.err_word       = err_word_q;
    assign bus.err_bits       = err_bits_q;
    assign bus.bit_err_count  = bit_cnt;
    assign bus.word_err_count = word_cnt;
endmodule
